led_pattern_scheduler: RTL and testbench

Shares the single user LED between `N_REQ` pattern requesters. Each requester submits a serial blink pattern, a length and a repeat count over a valid/ready handshake. The scheduler grants requesters round-robin and plays the granted pattern LSB-first, one bit per prescaled tick. It sits between the status/heartbeat/error sources in the top level and the `LED` pin.

---
 rtl/led_pattern_scheduler_pkg.sv | 21 ++
 rtl/led_pattern_scheduler_tick_prescaler.sv | 34 +++
 rtl/led_pattern_scheduler.sv | 163 ++++++++++++++++
 tb/tb_led_pattern_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_scheduler_pkg.sv
// Shared types and constants for the LED pattern scheduler.
// Holds the FSM state enum, default widths and a width helper.
package led_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

   localparam int PRESCALE_16MHZ_8HZ = 2_000_000;

   localparam int DEF_N_REQ = 2;
   localparam int DEF_PAT_W = 32;
   localparam int DEF_LEN_W = 5;
   localparam int DEF_REP_W = 4;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// Free-running bit-rate divider: one-cycle tick every PRESCALE cycles after clear.
module tick_prescaler
   import led_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_16MHZ_8HZ
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = clog2_min1(PRESCALE);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_W'(PRESCALE - 1));

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Round-robin arbiter that shares one LED between N_REQ serial blink-pattern requesters.
// Patterns play LSB-first, one bit per prescaler tick; all outputs except READY are registered.
module led_pattern_scheduler
   import led_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int PAT_W    = DEF_PAT_W,
   parameter int LEN_W    = DEF_LEN_W,
   parameter int REP_W    = DEF_REP_W,
   parameter int PRESCALE = PRESCALE_16MHZ_8HZ,
   localparam int ID_W    = clog2_min1(N_REQ)
) (
   input  logic                   CLK,
   input  logic                   RESETN,
   input  logic [N_REQ-1:0]       REQ_VALID,
   output logic [N_REQ-1:0]       REQ_READY,
   input  logic [N_REQ*PAT_W-1:0] REQ_PATTERN,
   input  logic [N_REQ*LEN_W-1:0] REQ_LEN,
   input  logic [N_REQ*REP_W-1:0] REQ_REPEAT,
   input  logic                   ABORT,
   output logic                   LED,
   output logic                   BUSY,
   output logic [ID_W-1:0]        ACTIVE_ID,
   output logic                   DONE
);

   localparam int IDX_W = clog2_min1(PAT_W);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [IDX_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               led_q, led_d;
   logic               done_q, done_d;

   logic [PAT_W-1:0]   req_pat [N_REQ];
   logic [LEN_W-1:0]   req_len [N_REQ];
   logic [REP_W-1:0]   req_rep [N_REQ];

   logic               tick;
   logic               found;
   logic [ID_W-1:0]    winner;
   logic [2*N_REQ-1:0] valid_rot;
   int                 cand;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_pat[gi] = REQ_PATTERN[gi*PAT_W +: PAT_W];
         assign req_len[gi] = REQ_LEN[gi*LEN_W +: LEN_W];
         assign req_rep[gi] = REQ_REPEAT[gi*REP_W +: REP_W];
      end
   endgenerate

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .CLK    (CLK),
      .RESETN (RESETN),
      .clear  (state_q != PLAY),
      .tick   (tick)
   );

   // Rotate VALID so the search always starts at bit 0 == rr pointer.
   always_comb begin
      found     = 1'b0;
      winner    = '0;
      cand      = 0;
      valid_rot = {REQ_VALID, REQ_VALID} >> rr_q;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && valid_rot[k]) begin
            found = 1'b1;
            cand  = int'(rr_q) + k;
            if (cand >= N_REQ) begin
               cand = cand - N_REQ;
            end
            winner = ID_W'(cand);
         end
      end
   end

   always_comb begin
      REQ_READY = '0;
      if (state_q == IDLE && found) begin
         REQ_READY[winner] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      rr_d    = rr_q;
      id_d    = id_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               pat_d   = req_pat[winner];
               len_d   = (int'(req_len[winner]) >= PAT_W) ? IDX_W'(PAT_W - 1)
                                                          : IDX_W'(req_len[winner]);
               idx_d   = '0;
               rep_d   = req_rep[winner];
               rr_d    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
               id_d    = winner;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (ABORT) begin
               state_d = IDLE;
            end else if (tick) begin
               if (idx_q < len_q) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (rep_q != '0) begin
                  rep_d = rep_q - REP_W'(1);
                  idx_d = '0;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // LED is registered from next-state values so it lines up with BUSY.
      led_d = (state_d == PLAY) ? pat_d[idx_d] : 1'b0;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         rr_q    <= '0;
         id_q    <= '0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

   assign LED       = led_q;
   assign BUSY      = (state_q == PLAY);
   assign ACTIVE_ID = id_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scenario bench for led_pattern_scheduler with PRESCALE=4, PAT_W=16.
module tb_led_pattern_scheduler;

   localparam int N_REQ = 2;
   localparam int PAT_W = 16;
   localparam int LEN_W = 5;
   localparam int REP_W = 4;
   localparam int PRESC = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*PAT_W-1:0] req_pattern;
   logic [N_REQ*LEN_W-1:0] req_len;
   logic [N_REQ*REP_W-1:0] req_repeat;
   logic                   abort;
   logic                   led;
   logic                   busy;
   logic [0:0]             active_id;
   logic                   done;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_rr   = 0;
   bit exp_led_q[$];

   always #5 clk = ~clk;

   led_pattern_scheduler #(
      .N_REQ    (N_REQ),
      .PAT_W    (PAT_W),
      .LEN_W    (LEN_W),
      .REP_W    (REP_W),
      .PRESCALE (PRESC)
   ) dut (
      .CLK         (clk),
      .RESETN      (rst_n),
      .REQ_VALID   (req_valid),
      .REQ_READY   (req_ready),
      .REQ_PATTERN (req_pattern),
      .REQ_LEN     (req_len),
      .REQ_REPEAT  (req_repeat),
      .ABORT       (abort),
      .LED         (led),
      .BUSY        (busy),
      .ACTIVE_ID   (active_id),
      .DONE        (done)
   );

   task automatic set_req(input int i, input logic [PAT_W-1:0] p, input int l, input int r);
      req_pattern[i*PAT_W +: PAT_W] = p;
      req_len[i*LEN_W +: LEN_W]     = LEN_W'(l);
      req_repeat[i*REP_W +: REP_W]  = REP_W'(r);
   endtask

   // Scoreboard: one expected LED value per clock of the whole playback.
   task automatic push_expected(input logic [PAT_W-1:0] p, input int l, input int r);
      int lc;
      lc = (l >= PAT_W) ? PAT_W - 1 : l;
      for (int rp = 0; rp <= r; rp++)
         for (int b = 0; b <= lc; b++)
            for (int c = 0; c < PRESC; c++)
               exp_led_q.push_back(p[b]);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      abort     = 1'b0;
      set_req(0, '0, 0, 0);
      set_req(1, '0, 0, 0);
      repeat (3) @(negedge clk);
      n_checks++; if (led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b expected 0", led); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (active_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", active_id); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: done");
   endtask

   task automatic test_single();
      bit e;
      set_req(0, 16'b1011, 3, 0);
      req_valid = 2'b01;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
      push_expected(16'b1011, 3, 0);
      exp_rr = 1;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (active_id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", active_id); end
      while (exp_led_q.size() > 0) begin
         e = exp_led_q.pop_front();
         n_checks++; if (led !== e) begin n_fail++; $display("FAIL single_led: got %b expected %b", led, e); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
         n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %b expected 0", done); end
         @(negedge clk);
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
      n_checks++; if (led !== 1'b0) begin n_fail++; $display("FAIL single_led_end: got %b expected 0", led); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", done); end
      $display("single: pattern 1011 len 3 played");
   endtask

   task automatic test_repeat();
      bit e;
      int pulses;
      pulses = 0;
      set_req(0, 16'b10, 1, 2);
      req_valid = 2'b01;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL repeat_ready: got %b expected 01", req_ready); end
      push_expected(16'b10, 1, 2);
      exp_rr = 1;
      @(negedge clk);
      req_valid = '0;
      while (exp_led_q.size() > 0) begin
         e = exp_led_q.pop_front();
         if (done) pulses++;
         n_checks++; if (led !== e) begin n_fail++; $display("FAIL repeat_led: got %b expected %b", led, e); end
         @(negedge clk);
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL repeat_done: got %b expected 1", done); end
      if (done) pulses++;
      @(negedge clk);
      if (done) pulses++;
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL repeat_pulses: got %0d expected 1", pulses); end
      $display("repeat: pattern 10 len 1 repeat 2 played");
   endtask

   task automatic test_round_robin();
      bit e;
      logic [N_REQ-1:0] exp_ready;
      set_req(0, 16'h0001, 1, 0);
      set_req(1, 16'h0002, 1, 0);
      req_valid = 2'b11;
      #1;
      for (int g = 0; g < 4; g++) begin
         int w;
         w = exp_rr;
         exp_ready = '0;
         exp_ready[w] = 1'b1;
         n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready: got %b expected %b", req_ready, exp_ready); end
         push_expected((w == 0) ? 16'h0001 : 16'h0002, 1, 0);
         exp_rr = (w + 1) % N_REQ;
         @(negedge clk);
         n_checks++; if (active_id !== 1'(w)) begin n_fail++; $display("FAIL rr_id: got %0d expected %0d", active_id, w); end
         while (exp_led_q.size() > 0) begin
            e = exp_led_q.pop_front();
            n_checks++; if (led !== e) begin n_fail++; $display("FAIL rr_led: got %b expected %b", led, e); end
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_ready_play: got %b expected 00", req_ready); end
            @(negedge clk);
         end
         n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rr_done: got %b expected 1", done); end
         if (g == 3) req_valid = '0;
         #1;
         $display("round_robin: grant %0d to requester %0d", g, w);
      end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_after: got %b expected 0", busy); end
   endtask

   task automatic test_abort();
      bit e;
      set_req(0, 16'h000D, 3, 0);
      req_valid = 2'b01;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL abort_ready0: got %b expected 01", req_ready); end
      push_expected(16'h000D, 3, 0);
      exp_rr = 1;
      @(negedge clk);
      set_req(1, 16'h0003, 1, 0);
      req_valid = 2'b10;
      for (int c = 0; c < 10; c++) begin
         e = exp_led_q.pop_front();
         n_checks++; if (led !== e) begin n_fail++; $display("FAIL abort_led: got %b expected %b", led, e); end
         n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL abort_pending_ready: got %b expected 00", req_ready); end
         if (c == 9) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      exp_led_q.delete();
      n_checks++; if (led !== 1'b0) begin n_fail++; $display("FAIL abort_led_off: got %b expected 0", led); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", done); end
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL abort_next_ready: got %b expected 10", req_ready); end
      push_expected(16'h0003, 1, 0);
      exp_rr = 0;
      @(negedge clk);
      req_valid = '0;
      e = exp_led_q.pop_front();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_req1_busy: got %b expected 1", busy); end
      n_checks++; if (active_id !== 1'b1) begin n_fail++; $display("FAIL abort_req1_id: got %0d expected 1", active_id); end
      n_checks++; if (led !== e) begin n_fail++; $display("FAIL abort_req1_led: got %b expected %b", led, e); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_led_q.delete();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort2_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort2_no_done: got %b expected 0", done); end
      $display("abort: req0 aborted in bit 2, req1 granted then aborted");
   endtask

   task automatic test_reset_mid();
      bit e;
      set_req(0, 16'hFFFF, 3, 0);
      req_valid = 2'b01;
      #1;
      exp_rr = 1;
      @(negedge clk);
      req_valid = '0;
      repeat (5) @(negedge clk);
      n_checks++; if (led !== 1'b1) begin n_fail++; $display("FAIL rstmid_led_before: got %b expected 1", led); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (led !== 1'b0) begin n_fail++; $display("FAIL rstmid_led_async: got %b expected 0", led); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_async: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done_async: got %b expected 0", done); end
      @(negedge clk);
      rst_n  = 1'b1;
      exp_rr = 0;
      set_req(0, 16'h0001, 0, 0);
      set_req(1, 16'h0003, 1, 0);
      req_valid = 2'b11;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 01", req_ready); end
      push_expected(16'h0001, 0, 0);
      exp_rr = 1;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (active_id !== 1'b0) begin n_fail++; $display("FAIL rstmid_id: got %0d expected 0", active_id); end
      while (exp_led_q.size() > 0) begin
         e = exp_led_q.pop_front();
         n_checks++; if (led !== e) begin n_fail++; $display("FAIL rstmid_led: got %b expected %b", led, e); end
         @(negedge clk);
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: got %b expected 1", done); end
      @(negedge clk);
      $display("reset_mid: async reset observed, req0 granted first");
   endtask

   task automatic test_clamp_stability();
      bit e;
      int k;
      k = 0;
      set_req(0, 16'hA5C3, 31, 0);
      req_valid = 2'b01;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL clamp_ready: got %b expected 01", req_ready); end
      push_expected(16'hA5C3, 31, 0);
      exp_rr = 1;
      @(negedge clk);
      req_valid = '0;
      while (exp_led_q.size() > 0) begin
         if (k == 10) set_req(0, 16'h5A3C, 0, 3);
         e = exp_led_q.pop_front();
         n_checks++; if (led !== e) begin n_fail++; $display("FAIL clamp_led: cycle %0d got %b expected %b", k, led, e); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clamp_busy: cycle %0d got %b expected 1", k, busy); end
         k++;
         @(negedge clk);
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clamp_done: got %b expected 1", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clamp_busy_end: got %b expected 0", busy); end
      @(negedge clk);
      $display("clamp: len 31 clamped, %0d cycles played", k);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_round_robin();
      test_abort();
      test_reset_mid();
      test_clamp_stability();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
